// File: rtl/nios2_clocks_pll_rst_seq.sv
// Reset/lock sequencer for the system PLL.
// Pulses the PLL reset and waits for a lock that stays stable.
// Only then releases the system reset to the Nios II fabric.
// Retries an attempt when lock times out, re-sequences when lock is lost,
// and reports status to software.
module nios2_clocks_pll_rst_seq #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int RELEASE_CYCLES = 64,
   parameter int MAX_RETRIES    = 3,
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
   input  logic          refclk,
   input  logic          rst,
   input  logic          pll_locked,
   input  logic          soft_rst_req,
   input  logic          clr_status,
   output logic          pll_rst,
   output logic          sys_rst,
   output logic          ready,
   output logic          fail,
   output logic          lock_lost,
   output logic [RW-1:0] retry_cnt,
   output logic [2:0]    state
);

   // One shared counter must hold the longest interval, which is the lock timeout.
   localparam int CMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int CMAX_B = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
   localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
   localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [RW-1:0] retry_reg, retry_next;
   logic          lock_lost_reg, lock_lost_next;
   logic          sync1_reg, lock_s_reg;
   logic          pll_rst_reg, sys_rst_reg, ready_reg, fail_reg;

   // State, counter, status flags, lock synchroniser, and registered output decode.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_PLL_RST;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         lock_lost_reg <= 1'b0;
         sync1_reg     <= 1'b0;
         lock_s_reg    <= 1'b0;
         pll_rst_reg   <= 1'b1;
         sys_rst_reg   <= 1'b1;
         ready_reg     <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         lock_lost_reg <= lock_lost_next;
         sync1_reg     <= pll_locked;
         lock_s_reg    <= sync1_reg;
         // Outputs follow the state being entered, so they change together with state.
         pll_rst_reg   <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
         sys_rst_reg   <= (state_next != ST_RUN);
         ready_reg     <= (state_next == ST_RUN);
         fail_reg      <= (state_next == ST_FAIL);
      end
   end

   // Next-state, counter, retry and sticky lock_lost logic.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = CW'(cnt_reg + 1'b1);
      retry_next     = retry_reg;
      lock_lost_next = lock_lost_reg & ~clr_status;

      // A lock drop while running is recorded even if clr_status arrives in the same cycle.
      if (state_reg == ST_RUN && !lock_s_reg) begin
         lock_lost_next = 1'b1;
      end

      unique case (state_reg)
         ST_PLL_RST: begin
            if (cnt_reg == CW'(PLL_RST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a timeout that lands in the same cycle.
            if (lock_s_reg) begin
               state_next = ST_STABLE;
            end else if (cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
               if (retry_reg == RW'(MAX_RETRIES)) begin
                  state_next = ST_FAIL;
               end else begin
                  retry_next = RW'(retry_reg + 1'b1);
                  state_next = ST_PLL_RST;
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s_reg) state_next = ST_WAIT_LOCK;
            else if (cnt_reg == CW'(STABLE_CYCLES - 1)) state_next = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!lock_s_reg) begin
               if (retry_reg == RW'(MAX_RETRIES)) begin
                  state_next = ST_FAIL;
               end else begin
                  retry_next = RW'(retry_reg + 1'b1);
                  state_next = ST_PLL_RST;
               end
            end else if (cnt_reg == CW'(RELEASE_CYCLES - 1)) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // Counter idles here so it can never wrap.
            cnt_next = cnt_reg;
            if (!lock_s_reg) begin
               retry_next = '0;
               state_next = ST_PLL_RST;
            end
         end
         ST_FAIL: begin
            cnt_next = cnt_reg;
         end
         default: begin
            state_next = ST_PLL_RST;
         end
      endcase

      // Software restart overrides everything except an ongoing PLL reset pulse.
      if (soft_rst_req && state_reg != ST_PLL_RST) begin
         state_next = ST_PLL_RST;
         retry_next = '0;
      end

      if (state_next != state_reg) cnt_next = '0;
   end

   assign pll_rst   = pll_rst_reg;
   assign sys_rst   = sys_rst_reg;
   assign ready     = ready_reg;
   assign fail      = fail_reg;
   assign lock_lost = lock_lost_reg;
   assign retry_cnt = retry_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_nios2_clocks_pll_rst_seq.sv
// Directed bench for the PLL reset/lock sequencer with short timing parameters.
module tb_nios2_clocks_pll_rst_seq;

   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 32;
   localparam int STABLE_CYCLES  = 8;
   localparam int RELEASE_CYCLES = 4;
   localparam int MAX_RETRIES    = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       clr_status = 1'b0;
   logic       pll_rst, sys_rst, ready, fail, lock_lost;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int vectors = 0;
   int miscompares = 0;
   int n;

   nios2_clocks_pll_rst_seq #(
      .PLL_RST_CYCLES(PLL_RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .soft_rst_req(soft_rst_req),
      .clr_status  (clr_status),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .fail        (fail),
      .lock_lost   (lock_lost),
      .retry_cnt   (retry_cnt),
      .state       (state)
   );

   // 100 MHz bench clock; period only matters relative to the 1-unit sample offset.
   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      $display("chk %-22s observed=%0d expected=%0d", tag, obs, exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         0:       return 32'(pll_rst);
         1:       return 32'(sys_rst);
         2:       return 32'(state);
         3:       return 32'(fail);
         default: return 32'hffff_ffff;
      endcase
   endfunction

   // Edges until the probed signal equals val; -1 if the budget runs out.
   task automatic edges_until(input int sel, input logic [31:0] val, input int budget, output int cnt);
      cnt = 0;
      while (cnt < budget) begin
         tick();
         cnt++;
         if (probe(sel) === val) return;
      end
      cnt = -1;
   endtask

   initial begin
      // Reset values, applied asynchronously before any clock edge.
      #1 rst = 1'b1;
      #2;
      check("rst_state", state, 0);
      check("rst_pll_rst", pll_rst, 1);
      check("rst_sys_rst", sys_rst, 1);
      check("rst_ready", ready, 0);
      check("rst_fail", fail, 0);
      check("rst_lock_lost", lock_lost, 0);
      check("rst_retry", retry_cnt, 0);
      #14 rst = 1'b0;

      // 1. Normal bring-up.
      edges_until(0, 0, 20, n);
      check("t1_pll_rst_len", n, 4);
      check("t1_wait_state", state, 1);
      repeat (10) tick();
      pll_locked = 1'b1;
      edges_until(1, 0, 40, n);
      check("t1_lock_to_sysrst", n, 15);
      check("t1_ready", ready, 1);
      check("t1_state", state, 4);
      check("t1_retry", retry_cnt, 0);
      check("t1_pll_rst", pll_rst, 0);

      // 5. Lock loss in RUN.
      pll_locked = 1'b0;
      tick();
      tick();
      check("t5_sysrst_hold", sys_rst, 0);
      tick();
      check("t5_sysrst", sys_rst, 1);
      check("t5_lock_lost", lock_lost, 1);
      check("t5_state", state, 0);
      check("t5_ready", ready, 0);
      check("t5_retry", retry_cnt, 0);
      pll_locked = 1'b1;
      edges_until(2, 4, 80, n);
      check("t5_rerun", state, 4);
      check("t5_sticky", lock_lost, 1);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("t5_cleared", lock_lost, 0);
      pll_locked = 1'b0;
      tick();
      tick();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("t5_set_wins", lock_lost, 1);
      check("t5_state2", state, 0);

      // 4. Lock glitch in STABLE at count 5.
      edges_until(2, 1, 20, n);
      check("t4_wait", state, 1);
      pll_locked = 1'b1;
      edges_until(2, 2, 40, n);
      check("t4_stable", state, 2);
      repeat (5) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      check("t4_still_stable", state, 2);
      tick();
      check("t4_back_wait", state, 1);
      check("t4_retry", retry_cnt, 0);
      edges_until(2, 3, 40, n);
      check("t4_restable_len", n, 9);
      edges_until(2, 4, 20, n);
      check("t4_run", state, 4);

      // 2. Timeout and retry, lock on the third attempt.
      soft_rst_req = 1'b1;
      pll_locked = 1'b0;
      tick();
      soft_rst_req = 1'b0;
      check("t2_soft_state", state, 0);
      check("t2_soft_sysrst", sys_rst, 1);
      check("t2_soft_retry", retry_cnt, 0);
      edges_until(0, 0, 20, n);
      check("t2_pulse1", n, 4);
      edges_until(0, 1, 60, n);
      check("t2_timeout1", n, 32);
      check("t2_retry1", retry_cnt, 1);
      edges_until(0, 0, 20, n);
      check("t2_pulse2", n, 4);
      edges_until(0, 1, 60, n);
      check("t2_timeout2", n, 32);
      check("t2_retry2", retry_cnt, 2);
      edges_until(0, 0, 20, n);
      check("t2_pulse3", n, 4);
      pll_locked = 1'b1;
      edges_until(2, 4, 80, n);
      check("t2_run", state, 4);
      check("t2_run_retry", retry_cnt, 2);
      check("t2_ready", ready, 1);

      // 3. Permanent no-lock.
      soft_rst_req = 1'b1;
      pll_locked = 1'b0;
      tick();
      soft_rst_req = 1'b0;
      check("t3_retry0", retry_cnt, 0);
      edges_until(3, 1, 200, n);
      check("t3_to_fail", n, 108);
      check("t3_state", state, 5);
      check("t3_sysrst", sys_rst, 1);
      check("t3_pll_rst", pll_rst, 1);
      check("t3_ready", ready, 0);
      check("t3_retry", retry_cnt, 2);
      repeat (5) tick();
      check("t3_stays", state, 5);
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      check("t3_soft_state", state, 0);
      check("t3_soft_retry", retry_cnt, 0);
      check("t3_soft_fail", fail, 0);

      // 6. Asynchronous reset during RELEASE, between clock edges.
      pll_locked = 1'b1;
      edges_until(2, 3, 80, n);
      check("t6_release", state, 3);
      check("t6_lock_lost_pre", lock_lost, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_state", state, 0);
      check("t6_pll_rst", pll_rst, 1);
      check("t6_sys_rst", sys_rst, 1);
      check("t6_lock_lost", lock_lost, 0);
      check("t6_retry", retry_cnt, 0);
      check("t6_ready", ready, 0);
      check("t6_fail", fail, 0);
      #3 rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
